// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and FSM state encoding.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MADD  = 3'b100,
    MD_MADDU = 3'b101,
    MD_MSUB  = 3'b110,
    MD_MSUBU = 3'b111
  } md_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result path: next {HI,LO} from latched op/operands and the
// current HI/LO. Accumulate ops exist only when MD_MADD_EN is defined.
module md_calc
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic [31:0] q;
  logic [31:0] r;

  // Low 64 bits of a product of sign-extended operands is the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'h0, a} * {32'h0, b};

  // NOTE: every output and temporary gets a default first so no path through
  // the case leaves a value unassigned, which would infer a latch.
  always_comb begin
    acc      = {hi, lo};
    div_zero = 1'b0;
    q        = '0;
    r        = '0;
    case (op)
      MD_MULT:  acc = prod_s;
      MD_MULTU: acc = prod_u;
      MD_DIV: begin
        if (b == 32'h0) begin
          div_zero = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          acc = {32'h0, 32'h8000_0000};
        end else begin
          q   = $signed(a) / $signed(b);
          r   = $signed(a) % $signed(b);
          acc = {r, q};
        end
      end
      MD_DIVU: begin
        if (b == 32'h0) begin
          div_zero = 1'b1;
        end else begin
          q   = a / b;
          r   = a % b;
          acc = {r, q};
        end
      end
`ifdef MD_MADD_EN
      MD_MADD:  acc = {hi, lo} + prod_s;
      MD_MADDU: acc = {hi, lo} + prod_u;
      MD_MSUB:  acc = {hi, lo} - prod_s;
      MD_MSUBU: acc = {hi, lo} - prod_u;
`endif
      default:  acc = {hi, lo};
    endcase
  end

  assign hi_nxt = acc[63:32];
  assign lo_nxt = acc[31:0];

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and fixed-latency Busy.
// Define MD_MADD_EN to enable madd/maddu/msub/msubu on md_op 1xx.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        mf_sel,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HILO
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  md_op_e      op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_nxt, lo_nxt;
  logic        div_zero;
  logic        op_valid;
  logic        launch;
  logic        write_res;
  logic        mt_en;

`ifdef MD_MADD_EN
  assign op_valid = 1'b1;
`else
  assign op_valid = ~md_op[2];
`endif

  md_calc u_calc (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi       (hi_q),
    .lo       (lo_q),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    launch    = 1'b0;
    write_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && op_valid) begin
          launch  = 1'b1;
          state_d = RUN;
          cnt_d   = is_div(md_op_e'(md_op)) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = IDLE;
          write_res = ~div_zero;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A launching start takes priority over a same-cycle move-to.
  assign mt_en = (state_q == IDLE) && !launch;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (write_res) begin
        hi_q <= hi_nxt;
        lo_q <= lo_nxt;
      end else if (mt_en) begin
        if (mthi) hi_q <= A;
        if (mtlo) lo_q <= A;
      end
    end
  end

  // NOTE: operand latches are not reset; they are only read while RUN, which
  // is always preceded by a load.
  always_ff @(posedge clk) begin
    if (launch) begin
      op_q <= md_op_e'(md_op);
      a_q  <= A;
      b_q  <= B;
    end
  end

  assign Busy  = (state_q == RUN);
  assign Stall = Busy | start;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign HILO  = mf_sel ? hi_q : lo_q;

endmodule
